nes_cart_mapper: RTL

- Parametrised cartridge block; successor to the fixed 16K-PRG/8K-CHR NROM ROM.
- Loads an iNES image from a byte stream and validates the header.
- Serves CPU PRG reads at $8000-$FFFF and PPU CHR reads at $0000-$1FFF, with NROM-128/256 PRG mirroring and CNROM-style CHR bank switching.
- Drives the nametable CIRAM A10 line from the header mirroring bit.

---
 rtl/nes_cart_mapper_if.sv | 29 ++
 rtl/nes_cart_mapper.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/nes_cart_mapper_if.sv
// Bus bundle for nes_cart_mapper: iNES loader stream, cartridge status,
// CPU PRG port and PPU CHR port. The clock and reset stay plain ports on the block.
interface nes_cart_mapper_if;
  logic        prog_start;
  logic        prog_valid;
  logic        prog_ready;
  logic [7:0]  prog_di;
  logic        cart_ok;
  logic        cart_err;
  logic [15:0] cpu_ab;
  logic        cpu_we;
  logic [7:0]  cpu_di;
  logic [7:0]  cpu_do;
  logic [13:0] ppu_ab;
  logic [7:0]  ppu_do;
  logic        ciram_a10;

  // Console / loader side
  modport master (
    output prog_start, prog_valid, prog_di, cpu_ab, cpu_we, cpu_di, ppu_ab,
    input  prog_ready, cart_ok, cart_err, cpu_do, ppu_do, ciram_a10
  );

  // Cartridge side
  modport slave (
    input  prog_start, prog_valid, prog_di, cpu_ab, cpu_we, cpu_di, ppu_ab,
    output prog_ready, cart_ok, cart_err, cpu_do, ppu_do, ciram_a10
  );
endinterface

// File: rtl/nes_cart_mapper.sv
// NROM/CNROM style cartridge: loads an iNES image from a byte stream, checks the
// header, then serves CPU PRG reads ($8000-$FFFF, NROM-128/256 mirroring) and PPU
// CHR reads ($0000-$1FFF, CPU-selected 8 KiB bank). ciram_a10 follows the header
// mirroring bit.
// Optional macro NES_CART_PRG_RAM_EN adds 8 KiB PRG RAM at $6000-$7FFF.
//
// Storage map: PRG at offset 0, CHR at offset PRG_BANKS*16384. The two regions are
// held in separate arrays so each one is a simple 1-write/1-read block RAM
// (loader writes, CPU or PPU reads).
module nes_cart_mapper #(
  parameter int PRG_BANKS = 2,
  parameter int CHR_BANKS = 4
) (
  input  logic             clk,
  input  logic             rst,
  nes_cart_mapper_if.slave bus
);
  localparam int PRG_BYTES   = PRG_BANKS * 16384;
  localparam int CHR_BYTES   = CHR_BANKS * 8192;
  localparam int STORE_BYTES = PRG_BYTES + CHR_BYTES;
  localparam int ADDR_W      = $clog2(STORE_BYTES);
  localparam int LW          = ADDR_W + 1;
  localparam int PRG_AW      = $clog2(PRG_BYTES);
  localparam int CB_W        = (CHR_BANKS > 1) ? $clog2(CHR_BANKS) : 1;
  localparam int CHR_AW      = CB_W + 13;

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_HDR  = 3'd1;
  localparam logic [2:0] ST_PRG  = 3'd2;
  localparam logic [2:0] ST_CHR  = 3'd3;
  localparam logic [2:0] ST_DONE = 3'd4;
  localparam logic [2:0] ST_ERR  = 3'd5;

  logic [2:0]        state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic [7:0]        prg_cnt_q, prg_cnt_d;
  logic [7:0]        chr_cnt_q, chr_cnt_d;
  logic              mirror_q, mirror_d;
  logic              magic_bad_q, magic_bad_d;
  logic [CB_W-1:0]   chr_bank_q, chr_bank_d;
  logic              prg_sel_q, prg_sel_d;
  logic              ppu_sel_q, ppu_sel_d;

  logic              ready_w, cart_ok_w, xfer;
  logic              prg_cnt_ok, chr_cnt_ok, hdr_ok;
  logic [LW-1:0]     prg_len, chr_len, cnt_inc;
  logic              prg_we, chr_we;
  logic [PRG_AW-1:0] prg_raddr;
  logic [CHR_AW-1:0] chr_raddr;
  logic [7:0]        prg_rd_q, chr_rd_q;

  assign ready_w   = (state_q == ST_HDR) || (state_q == ST_PRG) || (state_q == ST_CHR);
  assign cart_ok_w = (state_q == ST_DONE);
  // A prog_start in the same cycle wins; the byte presented with it is dropped.
  assign xfer      = bus.prog_valid && ready_w && !bus.prog_start;

  assign prg_cnt_ok = (prg_cnt_q != 8'd0) && (int'(prg_cnt_q) <= PRG_BANKS);
  assign chr_cnt_ok = ((chr_cnt_q == 8'd1) || (chr_cnt_q == 8'd2) || (chr_cnt_q == 8'd4))
                      && (int'(chr_cnt_q) <= CHR_BANKS);
  assign hdr_ok     = !magic_bad_q && prg_cnt_ok && chr_cnt_ok;

  // Region lengths only matter once the header has been accepted, so they fit LW bits.
  assign prg_len = LW'(prg_cnt_q) << 14;
  assign chr_len = LW'(chr_cnt_q) << 13;
  assign cnt_inc = LW'(cnt_q) + LW'(1);

  // Loader FSM, header capture and CPU-side CHR bank register
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    prg_cnt_d   = prg_cnt_q;
    chr_cnt_d   = chr_cnt_q;
    mirror_d    = mirror_q;
    magic_bad_d = magic_bad_q;
    chr_bank_d  = chr_bank_q;
    if (bus.prog_start) begin
      state_d     = ST_HDR;
      cnt_d       = '0;
      chr_bank_d  = '0;
      magic_bad_d = 1'b0;
    end else begin
      if (xfer) begin
        cnt_d = cnt_inc[ADDR_W-1:0];
        case (state_q)
          ST_HDR: begin
            case (cnt_q[3:0])
              4'd0:    magic_bad_d = magic_bad_q | (bus.prog_di != 8'h4E);
              4'd1:    magic_bad_d = magic_bad_q | (bus.prog_di != 8'h45);
              4'd2:    magic_bad_d = magic_bad_q | (bus.prog_di != 8'h53);
              4'd3:    magic_bad_d = magic_bad_q | (bus.prog_di != 8'h1A);
              4'd4:    prg_cnt_d   = bus.prog_di;
              4'd5:    chr_cnt_d   = bus.prog_di;
              4'd6:    mirror_d    = bus.prog_di[0];
              default: ;
            endcase
            if (cnt_q[3:0] == 4'hF) begin
              cnt_d   = '0;
              state_d = hdr_ok ? ST_PRG : ST_ERR;
            end
          end
          ST_PRG: begin
            if (cnt_inc == prg_len) begin
              cnt_d   = '0;
              state_d = ST_CHR;
            end
          end
          ST_CHR: begin
            if (cnt_inc == chr_len) begin
              cnt_d   = '0;
              state_d = ST_DONE;
            end
          end
          default: ;
        endcase
      end
      // Bank writes are masked to the number of banks in the image.
      if (cart_ok_w && bus.cpu_we && bus.cpu_ab[15]) begin
        chr_bank_d = CB_W'(bus.cpu_di & (chr_cnt_q - 8'd1));
      end
    end
  end

  // Read-source selects, registered alongside the memory read data
  always_comb begin
    prg_sel_d = cart_ok_w && bus.cpu_ab[15];
    ppu_sel_d = cart_ok_w && !bus.ppu_ab[13];
  end

  // Control state with asynchronous active-low reset
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      prg_cnt_q   <= 8'd0;
      chr_cnt_q   <= 8'd0;
      mirror_q    <= 1'b0;
      magic_bad_q <= 1'b0;
      chr_bank_q  <= '0;
      prg_sel_q   <= 1'b0;
      ppu_sel_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      prg_cnt_q   <= prg_cnt_d;
      chr_cnt_q   <= chr_cnt_d;
      mirror_q    <= mirror_d;
      magic_bad_q <= magic_bad_d;
      chr_bank_q  <= chr_bank_d;
      prg_sel_q   <= prg_sel_d;
      ppu_sel_q   <= ppu_sel_d;
    end
  end

  assign prg_we    = xfer && (state_q == ST_PRG);
  assign chr_we    = xfer && (state_q == ST_CHR);
  // NROM-128 images mirror the single 16 KiB bank into both halves of $8000-$FFFF.
  assign prg_raddr = PRG_AW'(bus.cpu_ab[14:0] & ((prg_cnt_q == 8'd1) ? 15'h3FFF : 15'h7FFF));
  assign chr_raddr = {chr_bank_q, bus.ppu_ab[12:0]};

  logic [7:0] prg_mem [PRG_BYTES];
  logic [7:0] chr_mem [CHR_BYTES];

  // PRG ROM: loader write port, CPU registered read port
  always_ff @(posedge clk) begin
    if (prg_we) prg_mem[cnt_q[PRG_AW-1:0]] <= bus.prog_di;
    prg_rd_q <= prg_mem[prg_raddr];
  end

  // CHR ROM: loader write port, PPU registered read port
  always_ff @(posedge clk) begin
    if (chr_we) chr_mem[cnt_q[CHR_AW-1:0]] <= bus.prog_di;
    chr_rd_q <= chr_mem[chr_raddr];
  end

`ifdef NES_CART_PRG_RAM_EN
  logic       ram_hit;
  logic       ram_sel_q, ram_sel_d;
  logic [7:0] ram_rd_q;
  logic [7:0] ram_mem [8192];

  assign ram_hit = (bus.cpu_ab[15:13] == 3'b011);

  // PRG RAM is usable whether or not an image is loaded
  always_comb begin
    ram_sel_d = ram_hit;
  end

  // PRG RAM read select
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) ram_sel_q <= 1'b0;
    else      ram_sel_q <= ram_sel_d;
  end

  // PRG RAM array, never cleared
  always_ff @(posedge clk) begin
    if (bus.cpu_we && ram_hit) ram_mem[bus.cpu_ab[12:0]] <= bus.cpu_di;
    ram_rd_q <= ram_mem[bus.cpu_ab[12:0]];
  end

  assign bus.cpu_do = prg_sel_q ? prg_rd_q : (ram_sel_q ? ram_rd_q : 8'h00);
`else
  assign bus.cpu_do = prg_sel_q ? prg_rd_q : 8'h00;
`endif

  assign bus.ppu_do     = ppu_sel_q ? chr_rd_q : 8'h00;
  assign bus.prog_ready = ready_w;
  assign bus.cart_ok    = cart_ok_w;
  assign bus.cart_err   = (state_q == ST_ERR);
  assign bus.ciram_a10  = mirror_q ? bus.ppu_ab[10] : bus.ppu_ab[11];
endmodule
